// File: rtl/axi_lite_ram_bridge.sv
// axi_lite_ram_bridge: AXI4-Lite slave that turns single transactions into one-cycle Ram commands
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   S_AW*/S_W*/S_B*     AXI4-Lite write address, data and response channels
//   S_AR*/S_R*          AXI4-Lite read address and data channels
//   RamWrite*/RamRead*  word address, data and size code towards the Ram wrapper
//   WriteEnable/ReadEnable  one-cycle command pulses
//   RamWriteReady/RamReadReady  completion pulses from the Ram wrapper
// Optional: define RAM_BRIDGE_TIMEOUT_EN to abort a stalled Ram access with SLVERR after 65535 cycles.
module axi_lite_ram_bridge #(
   parameter logic [63:0] RAM_BASE  = 64'h0000_0000_8000_0000,
   parameter logic [31:0] RAM_WORDS = 32'h0fff_ffff
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [63:0] S_AWADDR,
   input  logic        S_AWVALID,
   output logic        S_AWREADY,
   input  logic [63:0] S_WDATA,
   input  logic [7:0]  S_WSTRB,
   input  logic        S_WVALID,
   output logic        S_WREADY,
   output logic [1:0]  S_BRESP,
   output logic        S_BVALID,
   input  logic        S_BREADY,
   input  logic [63:0] S_ARADDR,
   input  logic        S_ARVALID,
   output logic        S_ARREADY,
   output logic [63:0] S_RDATA,
   output logic [1:0]  S_RRESP,
   output logic        S_RVALID,
   input  logic        S_RREADY,
   output logic [63:0] RamWriteAddr,
   output logic [63:0] RamWriteData,
   output logic [3:0]  RamWriteStrb,
   output logic [63:0] RamReadAddr,
   output logic        WriteEnable,
   output logic        ReadEnable,
   input  logic [63:0] RamReadData,
   input  logic        RamReadReady,
   input  logic        RamWriteReady
);
   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;
   state_t state_q;
   logic aw_full_q, w_full_q, ar_full_q, prefer_rd_q;
   logic [63:0] aw_addr_q, w_data_q, ar_addr_q;
   logic [7:0] w_strb_q;
`ifdef RAM_BRIDGE_TIMEOUT_EN
   logic [15:0] tmo_q;
`endif
   logic in_resp, w_in, r_in, w_ok, wr_go, rd_go;
   logic [63:0] w_off, r_off;
   logic [3:0] w_size;
   assign in_resp = state_q == WR_RESP || state_q == RD_RESP;
   // Gated by ARESET so every output reads 0 while reset is held.
   assign S_AWREADY = !ARESET && !aw_full_q && !in_resp;
   assign S_WREADY  = !ARESET && !w_full_q && !in_resp;
   assign S_ARREADY = !ARESET && !ar_full_q && !in_resp;
   assign w_off = aw_addr_q - RAM_BASE;
   assign r_off = ar_addr_q - RAM_BASE;
   assign w_in = aw_addr_q >= RAM_BASE && w_off[63:3] < {29'b0, RAM_WORDS};
   assign r_in = ar_addr_q >= RAM_BASE && r_off[63:3] < {29'b0, RAM_WORDS};
   assign w_size = w_strb_q == 8'h01 ? 4'd1 :
                   w_strb_q == 8'h03 ? 4'd2 :
                   w_strb_q == 8'h0F ? 4'd4 :
                   w_strb_q == 8'hFF ? 4'd8 : 4'd0;
   assign w_ok = w_in && |w_size;
   // On a tie the side that did not win last time goes first.
   assign wr_go = aw_full_q && w_full_q && (!ar_full_q || !prefer_rd_q);
   assign rd_go = ar_full_q && !wr_go;
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q      <= IDLE;
         aw_full_q    <= 1'b0;
         w_full_q     <= 1'b0;
         ar_full_q    <= 1'b0;
         prefer_rd_q  <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         ar_addr_q    <= '0;
         S_BRESP      <= '0;
         S_BVALID     <= 1'b0;
         S_RDATA      <= '0;
         S_RRESP      <= '0;
         S_RVALID     <= 1'b0;
         RamWriteAddr <= '0;
         RamWriteData <= '0;
         RamWriteStrb <= '0;
         RamReadAddr  <= '0;
         WriteEnable  <= 1'b0;
         ReadEnable   <= 1'b0;
`ifdef RAM_BRIDGE_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         if (S_AWVALID && S_AWREADY) begin
            aw_full_q <= 1'b1;
            aw_addr_q <= S_AWADDR;
         end
         if (S_WVALID && S_WREADY) begin
            w_full_q <= 1'b1;
            w_data_q <= S_WDATA;
            w_strb_q <= S_WSTRB;
         end
         if (S_ARVALID && S_ARREADY) begin
            ar_full_q <= 1'b1;
            ar_addr_q <= S_ARADDR;
         end
         WriteEnable <= 1'b0;
         ReadEnable  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_go) begin
                  prefer_rd_q <= 1'b1;
                  if (w_ok) begin
                     state_q      <= WR_ISSUE;
                     WriteEnable  <= 1'b1;
                     RamWriteAddr <= {3'b0, w_off[63:3]};
                     RamWriteData <= w_data_q;
                     RamWriteStrb <= w_size;
                  end else begin
                     state_q  <= WR_RESP;
                     S_BVALID <= 1'b1;
                     S_BRESP  <= 2'b10;
                  end
               end else if (rd_go) begin
                  prefer_rd_q <= 1'b0;
                  if (r_in) begin
                     state_q     <= RD_ISSUE;
                     ReadEnable  <= 1'b1;
                     RamReadAddr <= {3'b0, r_off[63:3]};
                  end else begin
                     state_q  <= RD_RESP;
                     S_RVALID <= 1'b1;
                     S_RRESP  <= 2'b10;
                     S_RDATA  <= '0;
                  end
               end
            end
            WR_ISSUE: begin
               state_q <= WR_WAIT;
`ifdef RAM_BRIDGE_TIMEOUT_EN
               tmo_q   <= '0;
`endif
            end
            WR_WAIT: begin
               if (RamWriteReady) begin
                  state_q  <= WR_RESP;
                  S_BVALID <= 1'b1;
                  S_BRESP  <= 2'b00;
               end
`ifdef RAM_BRIDGE_TIMEOUT_EN
               else if (tmo_q == 16'hFFFF) begin
                  state_q  <= WR_RESP;
                  S_BVALID <= 1'b1;
                  S_BRESP  <= 2'b10;
               end else tmo_q <= tmo_q + 16'd1;
`endif
            end
            WR_RESP: begin
               if (S_BREADY) begin
                  state_q   <= IDLE;
                  S_BVALID  <= 1'b0;
                  aw_full_q <= 1'b0;
                  w_full_q  <= 1'b0;
               end
            end
            RD_ISSUE: begin
               state_q <= RD_WAIT;
`ifdef RAM_BRIDGE_TIMEOUT_EN
               tmo_q   <= '0;
`endif
            end
            RD_WAIT: begin
               if (RamReadReady) begin
                  state_q  <= RD_RESP;
                  S_RVALID <= 1'b1;
                  S_RRESP  <= 2'b00;
                  S_RDATA  <= RamReadData;
               end
`ifdef RAM_BRIDGE_TIMEOUT_EN
               else if (tmo_q == 16'hFFFF) begin
                  state_q  <= RD_RESP;
                  S_RVALID <= 1'b1;
                  S_RRESP  <= 2'b10;
                  S_RDATA  <= '0;
               end else tmo_q <= tmo_q + 16'd1;
`endif
            end
            RD_RESP: begin
               if (S_RREADY) begin
                  state_q   <= IDLE;
                  S_RVALID  <= 1'b0;
                  ar_full_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// tb_axi_lite_ram_bridge: randomized self-checking bench with a Ram responder and a transaction-level reference model
module tb_axi_lite_ram_bridge;
   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] WORDS = 64'h0000_0000_0fff_ffff;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [63:0] S_AWADDR = '0, S_WDATA = '0, S_ARADDR = '0;
   logic [7:0] S_WSTRB = '0;
   logic S_AWVALID = 0, S_WVALID = 0, S_ARVALID = 0, S_BREADY = 0, S_RREADY = 0;
   logic S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID;
   logic [1:0] S_BRESP, S_RRESP;
   logic [63:0] S_RDATA, RamWriteAddr, RamWriteData, RamReadAddr;
   logic [3:0] RamWriteStrb;
   logic WriteEnable, ReadEnable;
   logic [63:0] RamReadData;
   logic RamReadReady, RamWriteReady;
   always #5 clk = ~clk;
   axi_lite_ram_bridge dut (
      .ACLK(clk), .ARESET(rst),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .RamWriteAddr(RamWriteAddr), .RamWriteData(RamWriteData), .RamWriteStrb(RamWriteStrb),
      .RamReadAddr(RamReadAddr), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
      .RamReadData(RamReadData), .RamReadReady(RamReadReady), .RamWriteReady(RamWriteReady)
   );
   int n_tests = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Ram responder: stores low N bytes on a write, answers each command after 1-4 cycles.
   logic [63:0] ram_mem [64];
   logic [63:0] rd_hold, last_waddr, last_wdata, last_raddr;
   logic [3:0] last_wstrb;
   int wcnt, rcnt;
   int we_cnt = 0, re_cnt = 0, both_cnt = 0;
   bit spur_req = 0, spur_ack = 0;
   function automatic logic [63:0] ram_merge(input logic [63:0] old, input logic [63:0] d, input logic [3:0] n);
      logic [63:0] m;
      m = (n == 4'd8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
      return (old & ~m) | (d & m);
   endfunction
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
         wcnt <= 0;
         rcnt <= 0;
         RamWriteReady <= 1'b0;
         RamReadReady <= 1'b0;
         RamReadData <= '0;
         spur_ack <= spur_req;
      end else begin
         RamWriteReady <= (wcnt == 1);
         RamReadReady <= (rcnt == 1);
         RamReadData <= (rcnt == 1) ? rd_hold : {$urandom, $urandom};
         if (wcnt > 0) wcnt <= wcnt - 1;
         if (rcnt > 0) rcnt <= rcnt - 1;
         if (spur_req != spur_ack) begin
            RamWriteReady <= 1'b1;
            RamReadReady <= 1'b1;
            spur_ack <= spur_req;
         end
         if (WriteEnable) begin
            ram_mem[RamWriteAddr[5:0]] <= ram_merge(ram_mem[RamWriteAddr[5:0]], RamWriteData, RamWriteStrb);
            wcnt <= $urandom_range(1, 4);
            we_cnt <= we_cnt + 1;
            last_waddr <= RamWriteAddr;
            last_wdata <= RamWriteData;
            last_wstrb <= RamWriteStrb;
         end
         if (ReadEnable) begin
            rd_hold <= ram_mem[RamReadAddr[5:0]];
            rcnt <= $urandom_range(1, 4);
            re_cnt <= re_cnt + 1;
            last_raddr <= RamReadAddr;
         end
         if (WriteEnable && ReadEnable) both_cnt <= both_cnt + 1;
      end
   end
   // Reference model: byte-addressed memory image plus the round-robin tie flag.
   logic [63:0] ref_mem [64];
   bit pref = 0;
   function automatic bit in_rng(input logic [63:0] a);
      logic [63:0] o;
      o = a - BASE;
      return a >= BASE && (o >> 3) < WORDS;
   endfunction
   function automatic bit strb_ok(input logic [7:0] s);
      int n;
      n = $countones(s);
      return (n == 1 || n == 2 || n == 4 || n == 8) && {8'b0, s} == (16'd1 << n) - 16'd1;
   endfunction
   task automatic run_txn(input string tag, input bit dw, input logic [63:0] wa, input logic [63:0] wd,
                          input logic [7:0] ws, input bit dr, input logic [63:0] ra, input int hold);
      bit w_ok, r_ok, w_first, got_b, got_r, aw_hs, w_hs, ar_hs;
      int we0, re0, b_at, r_at, cyc;
      logic [63:0] wo, ro, exp_r;
      wo = wa - BASE;
      ro = ra - BASE;
      w_ok = dw && in_rng(wa) && strb_ok(ws);
      r_ok = dr && in_rng(ra);
      w_first = dw && (!dr || !pref);
      if (dw && dr) pref = !w_first;
      else if (dw) pref = 1;
      else if (dr) pref = 0;
      if (!w_first) exp_r = r_ok ? ref_mem[ro[8:3]] : '0;
      if (w_ok) for (int b = 0; b < 8; b++) if (ws[b]) ref_mem[wo[8:3]][8*b +: 8] = wd[8*b +: 8];
      if (w_first) exp_r = r_ok ? ref_mem[ro[8:3]] : '0;
      spur_req = !spur_req;
      repeat (3) @(negedge clk);
      we0 = we_cnt;
      re0 = re_cnt;
      S_AWADDR = wa; S_WDATA = wd; S_WSTRB = ws; S_ARADDR = ra;
      S_AWVALID = dw; S_WVALID = dw; S_ARVALID = dr;
      got_b = 0; got_r = 0; b_at = 0; r_at = 0;
      for (cyc = 0; cyc < 300; cyc++) begin
         aw_hs = S_AWVALID && S_AWREADY;
         w_hs = S_WVALID && S_WREADY;
         ar_hs = S_ARVALID && S_ARREADY;
         S_BREADY = 0;
         S_RREADY = 0;
         if (S_BVALID && !got_b) begin
            got_b = 1;
            b_at = cyc;
            chk({tag, " bresp"}, S_BRESP, w_ok ? 2'b00 : 2'b10);
            repeat (hold) begin
               @(negedge clk);
               chk({tag, " bvalid_hold"}, S_BVALID, 1);
               chk({tag, " bresp_hold"}, S_BRESP, w_ok ? 2'b00 : 2'b10);
               chk({tag, " awready_hold"}, S_AWREADY, 0);
            end
            S_BREADY = 1;
         end
         if (S_RVALID && !got_r) begin
            got_r = 1;
            r_at = cyc;
            chk({tag, " rresp"}, S_RRESP, r_ok ? 2'b00 : 2'b10);
            chk({tag, " rdata"}, S_RDATA, exp_r);
            S_RREADY = 1;
         end
         @(negedge clk);
         if (aw_hs) S_AWVALID = 0;
         if (w_hs) S_WVALID = 0;
         if (ar_hs) S_ARVALID = 0;
         if (got_b == dw && got_r == dr && !S_AWVALID && !S_WVALID && !S_ARVALID && !S_BREADY && !S_RREADY) break;
      end
      S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0; S_BREADY = 0; S_RREADY = 0;
      chk({tag, " done"}, {got_b, got_r}, {dw, dr});
      if (dw && dr) chk({tag, " write_first"}, b_at < r_at, w_first);
      chk({tag, " we_pulses"}, we_cnt - we0, w_ok);
      chk({tag, " re_pulses"}, re_cnt - re0, r_ok);
      if (w_ok) begin
         chk({tag, " waddr"}, last_waddr, wo >> 3);
         chk({tag, " wstrb"}, last_wstrb, $countones(ws));
         chk({tag, " wdata"}, last_wdata, wd);
      end
      if (r_ok) chk({tag, " raddr"}, last_raddr, ro >> 3);
   endtask
   task automatic chk_reset_outs(input string tag);
      chk({tag, " ctrl"}, {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, WriteEnable, ReadEnable}, 0);
      chk({tag, " resp"}, {S_BRESP, S_RRESP, RamWriteStrb}, 0);
      chk({tag, " data"}, S_RDATA | RamWriteAddr | RamWriteData | RamReadAddr, 0);
   endtask
   function automatic logic [63:0] rnd_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return BASE - 64'd8 * $urandom_range(1, 4);
      if (r == 1) return BASE + WORDS * 8 + 64'($urandom_range(0, 63));
      if (r == 2) return BASE + (WORDS - 1) * 8;
      return BASE + 64'd8 * $urandom_range(0, 15) + 64'($urandom_range(0, 7));
   endfunction
   function automatic logic [7:0] rnd_strb();
      logic [7:0] legal [4];
      int r;
      legal = '{8'h01, 8'h03, 8'h0F, 8'hFF};
      r = $urandom_range(0, 5);
      return r < 4 ? legal[r] : r == 4 ? 8'($urandom) : 8'h02;
   endfunction
   initial begin
      int kind, we0;
      logic [63:0] a;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst = 0;
      @(negedge clk);
      chk("ready_after_reset", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);
      run_txn("tie_wr_first", 1, BASE + 64'h10, 64'h1122334455667788, 8'h0F, 1, BASE + 64'h10, 0);
      run_txn("bad_strb", 1, BASE + 64'h18, 64'hDEAD_BEEF_0000_0001, 8'h02, 0, '0, 0);
      run_txn("tie_rd_first", 1, BASE + 64'h20, 64'hCAFE_F00D_1234_5678, 8'hFF, 1, BASE + 64'h20, 0);
      run_txn("rd_below_base", 0, '0, '0, 8'h00, 1, BASE - 64'd8, 0);
      run_txn("rd_above_top", 0, '0, '0, 8'h00, 1, BASE + WORDS * 8, 0);
      run_txn("wr_top_word", 1, BASE + (WORDS - 1) * 8 + 64'd5, 64'h0102_0304_0506_0708, 8'h03, 0, '0, 0);
      run_txn("bresp_hold", 1, BASE + 64'h28, 64'h5A5A_A5A5_0F0F_F0F0, 8'h01, 0, '0, 5);
      run_txn("rd_after_hold", 0, '0, '0, 8'h00, 1, BASE + 64'h28, 0);
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 2);
         a = rnd_addr();
         run_txn($sformatf("rnd%0d", t), kind != 1, a, {$urandom, $urandom}, rnd_strb(),
                 kind != 0, $urandom_range(0, 1) ? a : rnd_addr(), kind == 0 ? $urandom_range(0, 3) : 0);
      end
      // Abort a write while the Ram access is still outstanding.
      @(negedge clk);
      we0 = we_cnt;
      S_AWADDR = BASE + 64'h8; S_WDATA = 64'hFFFF_0000_FFFF_0000; S_WSTRB = 8'hFF;
      S_AWVALID = 1; S_WVALID = 1;
      @(negedge clk);
      S_AWVALID = 0; S_WVALID = 0;
      for (int c = 0; c < 20 && we_cnt == we0; c++) @(negedge clk);
      chk("mid_we_seen", we_cnt - we0, 1);
      rst = 1;
      #1;
      chk_reset_outs("mid_reset");
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      pref = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      run_txn("post_reset_tie", 1, BASE + 64'h30, 64'h0BAD_F00D_7777_8888, 8'h0F, 1, BASE + 64'h8, 0);
      run_txn("post_reset_rd", 0, '0, '0, 8'h00, 1, BASE + 64'h30, 0);
      chk("never_both_enables", both_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
